vu_cmd_seq: RTL and testbench
=============================

Name: vu_cmd_seq

Overview:
- Front-end sequencer between the control-processor command/immediate queues and the vector issue stage.
- Pops one `XCMD` command, gathers its 0/1/2 immediates from the immediate queue, and presents one fully-formed issue packet.
- Tracks outstanding vector memory ops and holds fence commands until those ops drain.
- Command classification uses the `CMD_*` casez patterns from vuVXU-Opcode.vh.

Parameters:
- IMM_SZ, 64, width of each immediate.
- CNT_SZ, 4, width of outstanding-memory-op counter; MAXP = 2^CNT_SZ-1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command queue head valid.
- cmd_ready  out  1  command pop.
- cmd_bits  in  `XCMD_CMD_SZ  command.
- imm_valid  in  1  immediate queue head valid.
- imm_ready  out  1  immediate pop.
- imm_bits  in  IMM_SZ  immediate.
- issue_valid  out  1  packet valid.
- issue_ready  in  1  issue stage accepts.
- issue_cmd  out  `XCMD_CMD_SZ  latched command.
- issue_imm  out  IMM_SZ  first immediate (0 if none).
- issue_imm2  out  IMM_SZ  second immediate/stride (0 if none).
- issue_mem  out  1  packet is a vector memory op.
- mem_done  in  1  one memory op retired (pulse).
- fence_done  out  1  one-cycle pulse: fence completed.
- pending  out  CNT_SZ  outstanding memory op count.
- busy  out  1  state != IDLE or pending != 0.
- illegal  out  1  sticky: undefined command seen.

Behaviour:
- Classes:
  - FENCE = FENCE_L_V, FENCE_G_V, FENCE_L_CV, FENCE_G_CV.
  - NIMM0 = VMVV, VFMVV.
  - NIMM2 = VLST*, VSST*, VFLST*, VFSST* (strided).
  - NIMM1 = every other defined command.
  - MEM = all VL*/VS*/VFL*/VFS* load/store commands (unit, strided, indexed).
  - Anything else is undefined.
- States: IDLE, IMM1, IMM2, DISP, FENCE. Reset: state=IDLE; all outputs 0; pending=0; illegal=0; latched cmd/imm regs=0.
- IDLE:
  - cmd_ready=1. On cmd_valid, latch cmd, clear both imm regs, then:
    - FENCE -> FENCE.
    - NIMM0 -> DISP.
    - NIMM1/NIMM2 -> IMM1.
    - undefined -> stay IDLE, set illegal; command is consumed and dropped.
- IMM1: imm_ready=1. On imm_valid, latch issue_imm; -> IMM2 if NIMM2, else DISP.
- IMM2: imm_ready=1. On imm_valid, latch issue_imm2; -> DISP.
- DISP:
  - issue_valid=1 unless (issue_mem && pending==MAXP); in that case hold issue_valid=0 until pending drops.
  - Fire = issue_valid && issue_ready -> IDLE.
  - issue_valid must not drop, and packet fields must not change, once asserted until fire.
- FENCE: when pending==0 (checked against the registered value), pulse fence_done for 1 cycle and -> IDLE. The fence is never sent to the issue stage.
- Latency:
  - cmd pop at cycle t -> earliest issue_valid at t+1 (NIMM0), t+2 (NIMM1 with immediate already present), t+3 (NIMM2).
  - Fence with pending==0 popped at t -> fence_done at t+1.
- Throughput: at most one command in flight. cmd_ready=0 and imm_ready=0 in every state other than those listed above.
- Pending counter:
  - +1 on fire of a MEM packet; -1 on mem_done.
  - Both in the same cycle -> unchanged.
  - mem_done with pending==0 -> ignored, and illegal is set.
  - Never exceeds MAXP (guaranteed by the DISP stall).
- Immediate stream: immediates are consumed only in IMM1/IMM2, strictly in command order. A NIMM0 or fence command never pops an immediate.
- Reset mid-operation: reset returns to IDLE, drops any latched command/immediates without issuing, and clears pending and illegal. It takes priority over all events in the same cycle.
- busy: combinational from the registered state and pending.

Test Plan:
- NIMM0: VMVV with imm_valid=1, imm_bits=0x55 -> issue_valid at t+1, issue_imm=0, issue_mem=0, imm_ready never asserted; the 0x55 immediate stays in its queue.
- NIMM2: VLSTD, then immediates 0x1000 and 0x8 -> one packet with issue_imm=0x1000, issue_imm2=0x8, issue_mem=1; pending 0->1 on fire.
- Backpressure: VLD in DISP with issue_ready=0 for 5 cycles -> issue_valid held and packet stable; fires on the 6th cycle; pending=1.
- Fence drain: two VLW dispatched (pending=2), then FENCE_L_V -> fence_done stays 0 until two mem_done pulses; pulses 1 cycle after pending reaches 0. A simultaneous fire and mem_done leaves pending unchanged.
- Saturation (CNT_SZ=2): dispatch 3 VSD without mem_done -> the 4th VSD holds issue_valid=0. One mem_done -> issue_valid=1 the next cycle.
- Errors/reset: undefined cmd -> illegal=1, no packet, cmd popped. mem_done at pending=0 -> illegal=1. Reset asserted while in IMM2 -> IDLE next cycle with all outputs 0 and no issue.

Source files
------------

// File: rtl/vu_cmd_seq.sv
// vu_cmd_seq: front-end sequencer between the control-processor command and
// immediate queues and the vector issue stage. It pops one command, gathers
// its 0/1/2 immediates, presents one stable issue packet, counts outstanding
// vector memory ops and holds fences until those ops have retired.

package vu_cmd_seq_pkg;

    // Command layout: opcode in the top byte, operand fields below it.
    localparam int XCMD_CMD_SZ = 20;
    localparam int XCMD_OP_SZ  = 8;

    // Opcode map.
    //   0x01-0x02 register moves, no immediate (VMVV, VFMVV)
    //   0x03-0x06 other one-immediate commands (VF, VSETVL, VMSV, VFMSV)
    //   0x08-0x0B fences (FENCE_L_V, FENCE_G_V, FENCE_L_CV, FENCE_G_CV)
    //   0x20-0x2F unit-stride VL*/VS*/VFL*/VFS*, one immediate (base)
    //   0x30-0x3F strided VLST*/VSST*/VFLST*/VFSST*, two immediates (base, stride)
    //   0x40-0x4F indexed VL*/VS*/VFL*/VFS*, one immediate (base)
    //   everything else is undefined
    localparam logic [7:0] OP_VMVV       = 8'h01;
    localparam logic [7:0] OP_VFMVV      = 8'h02;
    localparam logic [7:0] OP_VF         = 8'h03;
    localparam logic [7:0] OP_VSETVL     = 8'h04;
    localparam logic [7:0] OP_VMSV       = 8'h05;
    localparam logic [7:0] OP_VFMSV      = 8'h06;
    localparam logic [7:0] OP_FENCE_L_V  = 8'h08;
    localparam logic [7:0] OP_FENCE_G_V  = 8'h09;
    localparam logic [7:0] OP_FENCE_L_CV = 8'h0A;
    localparam logic [7:0] OP_FENCE_G_CV = 8'h0B;
    localparam logic [7:0] OP_VLD        = 8'h20;
    localparam logic [7:0] OP_VLW        = 8'h21;
    localparam logic [7:0] OP_VSD        = 8'h28;
    localparam logic [7:0] OP_VLSTD      = 8'h30;
    localparam logic [7:0] OP_VLXD       = 8'h40;

    typedef enum logic [2:0] {
        CLS_UNDEF,
        CLS_FENCE,
        CLS_NIMM0,
        CLS_NIMM1,
        CLS_NIMM2
    } cmd_cls_e;

    typedef struct packed {
        cmd_cls_e cls;
        logic     mem;
    } cmd_class_t;

    function automatic cmd_class_t classify(input logic [XCMD_OP_SZ-1:0] op);
        cmd_class_t c;
        c.cls = CLS_UNDEF;
        c.mem = 1'b0;
        casez (op)
            8'b0000_0001,
            8'b0000_0010: c.cls = CLS_NIMM0;
            8'b0000_0011,
            8'b0000_0100,
            8'b0000_0101,
            8'b0000_0110: c.cls = CLS_NIMM1;
            8'b0000_10??: c.cls = CLS_FENCE;
            8'b0010_????: begin c.cls = CLS_NIMM1; c.mem = 1'b1; end
            8'b0011_????: begin c.cls = CLS_NIMM2; c.mem = 1'b1; end
            8'b0100_????: begin c.cls = CLS_NIMM1; c.mem = 1'b1; end
            default:      c.cls = CLS_UNDEF;
        endcase
        return c;
    endfunction

endpackage

module vu_cmd_seq
    import vu_cmd_seq_pkg::*;
#(
    parameter int IMM_SZ = 64,
    parameter int CNT_SZ = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [XCMD_CMD_SZ-1:0] cmd_bits,
    input  logic                   imm_valid,
    output logic                   imm_ready,
    input  logic [IMM_SZ-1:0]      imm_bits,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [XCMD_CMD_SZ-1:0] issue_cmd,
    output logic [IMM_SZ-1:0]      issue_imm,
    output logic [IMM_SZ-1:0]      issue_imm2,
    output logic                   issue_mem,
    input  logic                   mem_done,
    output logic                   fence_done,
    output logic [CNT_SZ-1:0]      pending,
    output logic                   busy,
    output logic                   illegal
);

    localparam logic [CNT_SZ-1:0] MAXP = '1;
    localparam logic [CNT_SZ-1:0] ONE  = CNT_SZ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IMM1,
        S_IMM2,
        S_DISP,
        S_FENCE
    } state_e;

    state_e                 state_q,   state_d;
    logic [XCMD_CMD_SZ-1:0] cmd_q,     cmd_d;
    logic [IMM_SZ-1:0]      imm_q,     imm_d;
    logic [IMM_SZ-1:0]      imm2_q,    imm2_d;
    logic [CNT_SZ-1:0]      pending_q, pending_d;
    logic                   illegal_q, illegal_d;

    cmd_class_t in_cls;
    cmd_class_t lat_cls;
    logic       fire;
    logic       bad_cmd;
    logic       mem_inc;
    logic       mem_dec;

    assign in_cls  = classify(cmd_bits[XCMD_CMD_SZ-1 -: XCMD_OP_SZ]);
    assign lat_cls = classify(cmd_q[XCMD_CMD_SZ-1 -: XCMD_OP_SZ]);

    // Next-state, queue pops and packet handshake for the one command in flight.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        cmd_d       = cmd_q;
        imm_d       = imm_q;
        imm2_d      = imm2_q;
        cmd_ready   = 1'b0;
        imm_ready   = 1'b0;
        issue_valid = 1'b0;
        fence_done  = 1'b0;
        fire        = 1'b0;
        bad_cmd     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Pops are held off during reset so no queue entry is consumed and then lost.
                cmd_ready = !reset;
                if (cmd_valid) begin
                    cmd_d  = cmd_bits;
                    imm_d  = '0;
                    imm2_d = '0;
                    unique case (in_cls.cls)
                        CLS_FENCE: state_d = S_FENCE;
                        CLS_NIMM0: state_d = S_DISP;
                        CLS_NIMM1,
                        CLS_NIMM2: state_d = S_IMM1;
                        default:   bad_cmd = 1'b1;
                    endcase
                end
            end
            S_IMM1: begin
                imm_ready = !reset;
                if (imm_valid) begin
                    imm_d   = imm_bits;
                    state_d = (lat_cls.cls == CLS_NIMM2) ? S_IMM2 : S_DISP;
                end
            end
            S_IMM2: begin
                imm_ready = !reset;
                if (imm_valid) begin
                    imm2_d  = imm_bits;
                    state_d = S_DISP;
                end
            end
            S_DISP: begin
                // A memory packet waits while the outstanding counter is full.
                issue_valid = !(lat_cls.mem && (pending_q == MAXP));
                if (issue_valid && issue_ready) begin
                    fire    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FENCE: begin
                if (pending_q == '0) begin
                    fence_done = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outstanding memory-op counter and sticky error flag.
    always_comb begin
        mem_inc   = fire && lat_cls.mem;
        mem_dec   = mem_done && (pending_q != '0);
        pending_d = pending_q;
        unique case ({mem_inc, mem_dec})
            2'b10:   pending_d = pending_q + ONE;
            2'b01:   pending_d = pending_q - ONE;
            default: pending_d = pending_q;
        endcase
        illegal_d = illegal_q | bad_cmd | (mem_done && (pending_q == '0));
    end

    // State registers; reset wins over every event in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            imm_q     <= '0;
            imm2_q    <= '0;
            pending_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            imm_q     <= imm_d;
            imm2_q    <= imm2_d;
            pending_q <= pending_d;
            illegal_q <= illegal_d;
        end
    end

    assign issue_cmd  = cmd_q;
    assign issue_imm  = imm_q;
    assign issue_imm2 = imm2_q;
    assign issue_mem  = lat_cls.mem;
    assign pending    = pending_q;
    assign illegal    = illegal_q;
    assign busy       = (state_q != S_IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_vu_cmd_seq.sv
// Testbench for vu_cmd_seq: a table of per-cycle input/expected-output
// records, plus a hand-written check that a fence pulses exactly once.
module tb_vu_cmd_seq;
    import vu_cmd_seq_pkg::*;

    localparam int IMM_SZ = 64;
    localparam int CNT_SZ = 2;

    localparam logic [19:0] C_VMVV  = {OP_VMVV,       12'hA5C};
    localparam logic [19:0] C_VLSTD = {OP_VLSTD,      12'h3C1};
    localparam logic [19:0] C_VLD   = {OP_VLD,        12'h111};
    localparam logic [19:0] C_VLW   = {OP_VLW,        12'h222};
    localparam logic [19:0] C_VSD   = {OP_VSD,        12'h333};
    localparam logic [19:0] C_FLV   = {OP_FENCE_L_V,  12'h000};
    localparam logic [19:0] C_FGV   = {OP_FENCE_G_V,  12'h000};
    localparam logic [19:0] C_FGCV  = {OP_FENCE_G_CV, 12'h000};
    localparam logic [19:0] C_UNDEF = {8'hFF,         12'h0F0};

    logic                   clk;
    logic                   reset;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [XCMD_CMD_SZ-1:0] cmd_bits;
    logic                   imm_valid;
    logic                   imm_ready;
    logic [IMM_SZ-1:0]      imm_bits;
    logic                   issue_valid;
    logic                   issue_ready;
    logic [XCMD_CMD_SZ-1:0] issue_cmd;
    logic [IMM_SZ-1:0]      issue_imm;
    logic [IMM_SZ-1:0]      issue_imm2;
    logic                   issue_mem;
    logic                   mem_done;
    logic                   fence_done;
    logic [CNT_SZ-1:0]      pending;
    logic                   busy;
    logic                   illegal;

    vu_cmd_seq #(.IMM_SZ(IMM_SZ), .CNT_SZ(CNT_SZ)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_bits    (cmd_bits),
        .imm_valid   (imm_valid),
        .imm_ready   (imm_ready),
        .imm_bits    (imm_bits),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_cmd   (issue_cmd),
        .issue_imm   (issue_imm),
        .issue_imm2  (issue_imm2),
        .issue_mem   (issue_mem),
        .mem_done    (mem_done),
        .fence_done  (fence_done),
        .pending     (pending),
        .busy        (busy),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        cv;
        logic [19:0] cmd;
        logic        iv;
        logic [63:0] imm;
        logic        ir;
        logic        md;
        logic        crdy;
        logic        irdy;
        logic        ivld;
        logic [19:0] icmd;
        logic [63:0] iimm;
        logic [63:0] iimm2;
        logic        imem;
        logic        fd;
        logic [1:0]  pend;
        logic        busy;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(
        input longint unsigned rst, cv, cmd, iv, imm, ir, md,
        input longint unsigned crdy, irdy, ivld, icmd, iimm, iimm2, imem, fd, pend, bsy, ill);
        vec_t v;
        v.rst  = 1'(rst);   v.cv   = 1'(cv);   v.cmd   = 20'(cmd);
        v.iv   = 1'(iv);    v.imm  = 64'(imm); v.ir    = 1'(ir);
        v.md   = 1'(md);    v.crdy = 1'(crdy); v.irdy  = 1'(irdy);
        v.ivld = 1'(ivld);  v.icmd = 20'(icmd); v.iimm = 64'(iimm);
        v.iimm2 = 64'(iimm2); v.imem = 1'(imem); v.fd  = 1'(fd);
        v.pend = 2'(pend);  v.busy = 1'(bsy);  v.ill   = 1'(ill);
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset       = v.rst;
        cmd_valid   = v.cv;
        cmd_bits    = v.cmd;
        imm_valid   = v.iv;
        imm_bits    = v.imm;
        issue_ready = v.ir;
        mem_done    = v.md;
    endtask

    task automatic compare(input vec_t v, input int idx);
        check("cmd_ready",   idx, 64'(cmd_ready),   64'(v.crdy));
        check("imm_ready",   idx, 64'(imm_ready),   64'(v.irdy));
        check("issue_valid", idx, 64'(issue_valid), 64'(v.ivld));
        check("issue_cmd",   idx, 64'(issue_cmd),   64'(v.icmd));
        check("issue_imm",   idx, issue_imm,        v.iimm);
        check("issue_imm2",  idx, issue_imm2,       v.iimm2);
        check("issue_mem",   idx, 64'(issue_mem),   64'(v.imem));
        check("fence_done",  idx, 64'(fence_done),  64'(v.fd));
        check("pending",     idx, 64'(pending),     64'(v.pend));
        check("busy",        idx, 64'(busy),        64'(v.busy));
        check("illegal",     idx, 64'(illegal),     64'(v.ill));
    endtask

    initial begin
        int pulses;
        reset = 1'b1; cmd_valid = 1'b0; cmd_bits = '0; imm_valid = 1'b0;
        imm_bits = '0; issue_ready = 1'b0; mem_done = 1'b0;
        repeat (2) @(posedge clk);

        //                 rst cv cmd     iv imm      ir md | crdy irdy ivld icmd    iimm     iimm2 mem fd pend busy ill
        // Reset state, then VMVV with an immediate sitting in the queue.
        vecs.push_back(mk(1, 0, 0,       0, 0,       0, 0,   0, 0, 0, 0,       0,       0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,   1, 0, 0, 0,       0,       0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, C_VMVV,  1, 'h55,    0, 0,   1, 0, 0, 0,       0,       0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h55,    0, 0,   0, 0, 1, C_VMVV,  0,       0,    0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h55,    1, 0,   0, 0, 1, C_VMVV,  0,       0,    0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h55,    0, 0,   1, 0, 0, C_VMVV,  0,       0,    0, 0, 0, 0, 0));
        // Strided load: two immediates, fire raises pending.
        vecs.push_back(mk(0, 1, C_VLSTD, 0, 0,       0, 0,   1, 0, 0, C_VMVV,  0,       0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h1000,  0, 0,   0, 1, 0, C_VLSTD, 0,       0,    1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h8,     0, 0,   0, 1, 0, C_VLSTD, 'h1000,  0,    1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0,   0, 0, 1, C_VLSTD, 'h1000,  'h8,  1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,   1, 0, 0, C_VLSTD, 'h1000,  'h8,  1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 1,   1, 0, 0, C_VLSTD, 'h1000,  'h8,  1, 0, 1, 1, 0));
        // VLD under 5 cycles of backpressure, fires on the 6th.
        vecs.push_back(mk(0, 1, C_VLD,   1, 'h77,    0, 0,   1, 0, 0, C_VLSTD, 'h1000,  'h8,  1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h77,    0, 0,   0, 1, 0, C_VLD,   0,       0,    1, 0, 0, 1, 0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 0, 0,   0, 0,       0, 0,   0, 0, 1, C_VLD,   'h77,    0,    1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0,   0, 0, 1, C_VLD,   'h77,    0,    1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 1,   1, 0, 0, C_VLD,   'h77,    0,    1, 0, 1, 1, 0));
        // Two VLW to pending=2, then a fence drained by two mem_done pulses.
        vecs.push_back(mk(0, 1, C_VLW,   1, 'h10,    0, 0,   1, 0, 0, C_VLD,   'h77,    0,    1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h10,    0, 0,   0, 1, 0, C_VLW,   0,       0,    1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0,   0, 0, 1, C_VLW,   'h10,    0,    1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, C_VLW,   1, 'h20,    0, 0,   1, 0, 0, C_VLW,   'h10,    0,    1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h20,    0, 0,   0, 1, 0, C_VLW,   0,       0,    1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0,   0, 0, 1, C_VLW,   'h20,    0,    1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, C_FLV,   0, 0,       0, 0,   1, 0, 0, C_VLW,   'h20,    0,    1, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 1,   0, 0, 0, C_FLV,   0,       0,    0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 1,   0, 0, 0, C_FLV,   0,       0,    0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,   0, 0, 0, C_FLV,   0,       0,    0, 1, 0, 1, 0));
        // Fire and mem_done in the same cycle leave pending unchanged.
        vecs.push_back(mk(0, 1, C_VLW,   1, 'h30,    0, 0,   1, 0, 0, C_FLV,   0,       0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h30,    0, 0,   0, 1, 0, C_VLW,   0,       0,    1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0,   0, 0, 1, C_VLW,   'h30,    0,    1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, C_VLW,   1, 'h40,    0, 0,   1, 0, 0, C_VLW,   'h30,    0,    1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h40,    0, 0,   0, 1, 0, C_VLW,   0,       0,    1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 1,   0, 0, 1, C_VLW,   'h40,    0,    1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 1,   1, 0, 0, C_VLW,   'h40,    0,    1, 0, 1, 1, 0));
        // Saturation with MAXP=3: fourth VSD stalls until one mem_done.
        vecs.push_back(mk(0, 1, C_VSD,   1, 'h100,   0, 0,   1, 0, 0, C_VLW,   'h40,    0,    1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h100,   0, 0,   0, 1, 0, C_VSD,   0,       0,    1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0,   0, 0, 1, C_VSD,   'h100,   0,    1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, C_VSD,   1, 'h200,   0, 0,   1, 0, 0, C_VSD,   'h100,   0,    1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h200,   0, 0,   0, 1, 0, C_VSD,   0,       0,    1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0,   0, 0, 1, C_VSD,   'h200,   0,    1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, C_VSD,   1, 'h300,   0, 0,   1, 0, 0, C_VSD,   'h200,   0,    1, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h300,   0, 0,   0, 1, 0, C_VSD,   0,       0,    1, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0,   0, 0, 1, C_VSD,   'h300,   0,    1, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, C_VSD,   1, 'h400,   0, 0,   1, 0, 0, C_VSD,   'h300,   0,    1, 0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0,       1, 'h400,   0, 0,   0, 1, 0, C_VSD,   0,       0,    1, 0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0,   0, 0, 0, C_VSD,   'h400,   0,    1, 0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 1,   0, 0, 0, C_VSD,   'h400,   0,    1, 0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,   0, 0, 1, C_VSD,   'h400,   0,    1, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0,   0, 0, 1, C_VSD,   'h400,   0,    1, 0, 2, 1, 0));
        // Undefined command: consumed, no packet, illegal set; then drain.
        vecs.push_back(mk(0, 1, C_UNDEF, 0, 0,       0, 0,   1, 0, 0, C_VSD,   'h400,   0,    1, 0, 3, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 1,   1, 0, 0, C_UNDEF, 0,       0,    0, 0, 3, 1, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 1,   1, 0, 0, C_UNDEF, 0,       0,    0, 0, 2, 1, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 1,   1, 0, 0, C_UNDEF, 0,       0,    0, 0, 1, 1, 1));
        // Reset clears illegal; mem_done at pending=0 sets it again.
        vecs.push_back(mk(1, 0, 0,       0, 0,       0, 0,   0, 0, 0, C_UNDEF, 0,       0,    0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 1,   1, 0, 0, 0,       0,       0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,   1, 0, 0, 0,       0,       0,    0, 0, 0, 0, 1));
        // Reset while in IMM2 drops the command without issuing.
        vecs.push_back(mk(0, 1, C_VLSTD, 0, 0,       0, 0,   1, 0, 0, 0,       0,       0,    0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0,       1, 'hAA,    0, 0,   0, 1, 0, C_VLSTD, 0,       0,    1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0,       1, 'hBB,    1, 0,   0, 0, 0, C_VLSTD, 'hAA,    0,    1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       1, 0,   1, 0, 0, 0,       0,       0,    0, 0, 0, 0, 0));
        // Fence with nothing outstanding: fence_done the cycle after the pop.
        vecs.push_back(mk(0, 1, C_FGCV,  0, 0,       0, 0,   1, 0, 0, 0,       0,       0,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,   0, 0, 0, C_FGCV,  0,       0,    0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,   1, 0, 0, C_FGCV,  0,       0,    0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            @(posedge clk);
            #2;
            drive(vecs[i]);
            @(negedge clk);
            compare(vecs[i], i);
        end

        // A fence popped at pending=0 pulses fence_done for exactly one cycle.
        @(posedge clk);
        #2;
        cmd_valid = 1'b1;
        cmd_bits  = C_FGV;
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        cmd_bits  = '0;
        pulses    = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (fence_done === 1'b1) pulses++;
        end
        check("fence_pulse_count", -1, 64'(pulses), 64'd1);
        check("busy_after_fence", -1, 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
